// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Shared bus widths, load opcodes and load-type decode for mem_stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam int EXE_MEM_BUS_W = 103;
  localparam int MEM_WB_BUS_W  = 70;
  localparam int MEM_WR_BUS_W  = 38;

  // Opcodes live in inst[31:22]
  localparam logic [9:0] OP_LD_B  = 10'b0010100000;
  localparam logic [9:0] OP_LD_H  = 10'b0010100001;
  localparam logic [9:0] OP_LD_W  = 10'b0010100010;
  localparam logic [9:0] OP_LD_BU = 10'b0010101000;
  localparam logic [9:0] OP_LD_HU = 10'b0010101001;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } load_type_e;

  // Unrecognised opcodes fall back to a full-word pass-through
  function automatic load_type_e decode_load(input logic [9:0] op);
    case (op)
      OP_LD_B:  return LD_B;
      OP_LD_H:  return LD_H;
      OP_LD_BU: return LD_BU;
      OP_LD_HU: return LD_HU;
      default:  return LD_W;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ============================================================================
// Module : load_align
// Brief  : Byte/halfword lane select with sign or zero extension.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import mem_stage_pkg::*;
(
  input  load_type_e  i_type,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    // Misaligned halfwords are not trapped; only offset[1] picks the lane
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (i_type)
      LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_data = {24'h0, w_byte};
      LD_H:    o_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module : mem_stage
// Brief  : MEM pipeline stage: load data capture/hold, result mux, WB handoff.
//          Macro MEM_SUBWORD_LOAD_EN enables sub-word load extraction.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exe_mem_valid,
  output logic                     mem_allowin,
  input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus,
  input  logic [31:0]              data_sram_rdata,
  output logic                     mem_wb_valid,
  input  logic                     wb_allowin,
  output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus,
  output logic [MEM_WR_BUS_W-1:0]  mem_wr_bus
);

  logic                     r_valid;
  logic [EXE_MEM_BUS_W-1:0] r_bus;
  logic                     r_held;
  logic [31:0]              r_rdata_buf;

  logic        w_ready_go;
  logic        w_gr_we;
  logic        w_res_from_mem;
  logic [4:0]  w_dest;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic [31:0] w_result;
  logic [31:0] w_word;
  logic [31:0] w_load_data;
  logic [31:0] w_final;
  logic        w_leave;

  assign {w_gr_we, w_res_from_mem, w_dest, w_pc, w_inst, w_result} = r_bus;

  assign w_ready_go   = 1'b1;
  // Reset gating keeps the handshake quiet even before the first reset edge
  assign mem_wb_valid = r_valid & w_ready_go & ~reset;
  assign mem_allowin  = ~r_valid | (w_ready_go & wb_allowin) | reset;
  assign w_leave      = mem_wb_valid & wb_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (mem_allowin) begin
      r_valid <= exe_mem_valid;
    end
  end

  // Bus register is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (exe_mem_valid && mem_allowin && !reset) begin
      r_bus <= exe_mem_bus;
    end
  end

  // The SRAM only drives valid data for one cycle, so a stalled load keeps its own copy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held      <= 1'b0;
      r_rdata_buf <= 32'h0;
    end else if (w_leave) begin
      r_held      <= 1'b0;
    end else if (r_valid && !r_held) begin
      r_held      <= 1'b1;
      r_rdata_buf <= data_sram_rdata;
    end
  end

  assign w_word = r_held ? r_rdata_buf : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
  load_type_e w_load_type;
  logic       w_unused;

  assign w_load_type = decode_load(w_inst[31:22]);
  assign w_unused    = ^w_inst[21:0];

  load_align u_load_align (
    .i_type   (w_load_type),
    .i_offset (w_result[1:0]),
    .i_word   (w_word),
    .o_data   (w_load_data)
  );
`else
  logic w_unused;

  assign w_unused    = ^w_inst;
  assign w_load_data = w_word;
`endif

  assign w_final    = w_res_from_mem ? w_load_data : w_result;
  assign mem_wb_bus = {w_gr_we, w_dest, w_pc, w_final};
  assign mem_wr_bus = {mem_wb_valid & w_gr_we, w_dest, w_final};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module : tb_mem_stage
// Brief  : Self-checking bench for mem_stage (table, directed, random).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         exe_mem_valid;
  logic         mem_allowin;
  logic [102:0] exe_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic         mem_wb_valid;
  logic         wb_allowin;
  logic [69:0]  mem_wb_bus;
  logic [37:0]  mem_wr_bus;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .exe_mem_valid   (exe_mem_valid),
    .mem_allowin     (mem_allowin),
    .exe_mem_bus     (exe_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_wb_valid    (mem_wb_valid),
    .wb_allowin      (wb_allowin),
    .mem_wb_bus      (mem_wb_bus),
    .mem_wr_bus      (mem_wr_bus)
  );

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [102:0] mk(input bit gr_we, input bit rfm, input logic [4:0] dest,
                                      input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [31:0] result);
    return {gr_we, rfm, dest, pc, inst, result};
  endfunction

  // Reference result from the architectural load rules
  function automatic logic [31:0] ref_final(input logic [31:0] inst, input logic [31:0] result,
                                            input logic [31:0] word, input bit rfm);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    if (!rfm) return result;
`ifdef MEM_SUBWORD_LOAD_EN
    sh = word >> (8 * result[1:0]);
    b  = sh[7:0];
    sh = word >> (16 * result[1]);
    h  = sh[15:0];
    case (inst[31:22])
      10'b0010100000: return (b >= 8'd128) ? 32'hFFFFFF00 | 32'(b) : 32'(b);
      10'b0010101000: return 32'(b);
      10'b0010100001: return (h >= 16'h8000) ? 32'hFFFF0000 | 32'(h) : 32'(h);
      10'b0010101001: return 32'(h);
      default:        return word;
    endcase
`else
    sh = inst;
    b  = sh[7:0];
    h  = sh[15:0];
    return word;
`endif
  endfunction

  typedef struct {
    logic [9:0]  op;
    logic [31:0] result;
    logic [31:0] rdata;
    bit          rfm;
    logic [31:0] exp_sub;
  } vec_t;

  vec_t tbl[8];

  logic [9:0] ops[6];

  // Random-phase model state
  bit           m_valid;
  bit           m_first;
  logic [102:0] m_bus;
  logic [31:0]  m_word;

  initial begin
    logic [31:0] exp_f;
    logic [31:0] word;
    logic [31:0] inst;

    tbl[0] = '{10'b0010100000, 32'h1003, 32'h80FF7F01, 1'b1, 32'hFFFFFF80};
    tbl[1] = '{10'b0010101001, 32'h1002, 32'hBEEF1234, 1'b1, 32'h0000BEEF};
    tbl[2] = '{10'b0010100001, 32'h2000, 32'h12348001, 1'b1, 32'hFFFF8001};
    tbl[3] = '{10'b0010101000, 32'h2001, 32'h0000A500, 1'b1, 32'h000000A5};
    tbl[4] = '{10'b0010100010, 32'h3002, 32'hCAFEBABE, 1'b1, 32'hCAFEBABE};
    tbl[5] = '{10'b0010100001, 32'h3003, 32'h7ABC0001, 1'b1, 32'h00007ABC};
    tbl[6] = '{10'b0010100000, 32'h4000, 32'h0000017F, 1'b1, 32'h0000007F};
    tbl[7] = '{10'b0010100000, 32'h00ABCDEF, 32'h55555555, 1'b0, 32'h00ABCDEF};
    ops = '{10'b0010100000, 10'b0010100001, 10'b0010100010,
            10'b0010101000, 10'b0010101001, 10'b0000010000};

    reset           = 1'b1;
    exe_mem_valid   = 1'b0;
    wb_allowin      = 1'b1;
    exe_mem_bus     = '0;
    data_sram_rdata = '0;

    tick();
    @(negedge clk);
    chk("rst_wb_valid", 70'(mem_wb_valid), 70'(1'b0));
    chk("rst_allowin", 70'(mem_allowin), 70'(1'b1));
    chk("rst_bypass", 70'(mem_wr_bus[37]), 70'(1'b0));
    tick();
    reset = 1'b0;

    // Table: one-cycle pass-through of each load pattern
    for (int i = 0; i < 8; i++) begin
      exe_mem_valid = 1'b1;
      exe_mem_bus   = mk(1'b1, tbl[i].rfm, 5'(i + 1), 32'h1C00_0000 + 32'(4 * i),
                         {tbl[i].op, 22'h15A5A}, tbl[i].result);
      tick();
      exe_mem_valid   = 1'b0;
      data_sram_rdata = tbl[i].rdata;
`ifdef MEM_SUBWORD_LOAD_EN
      exp_f = tbl[i].exp_sub;
`else
      exp_f = tbl[i].rfm ? tbl[i].rdata : tbl[i].result;
`endif
      @(negedge clk);
      chk($sformatf("tbl%0d_final", i), 70'(mem_wb_bus[31:0]), 70'(exp_f));
      chk($sformatf("tbl%0d_valid", i), 70'(mem_wb_valid), 70'(1'b1));
    end
    tick();

    // Stall: the first-cycle word must survive SRAM data changing
    exe_mem_valid = 1'b1;
    wb_allowin    = 1'b0;
    exe_mem_bus   = mk(1'b1, 1'b1, 5'd3, 32'h1C00_1000, {10'b0010100010, 22'h0}, 32'h100);
    tick();
    exe_mem_valid   = 1'b0;
    data_sram_rdata = 32'h12345678;
    @(negedge clk);
    chk("stall_c1_final", 70'(mem_wb_bus[31:0]), 70'(32'h12345678));
    chk("stall_c1_allowin", 70'(mem_allowin), 70'(1'b0));
    tick();
    data_sram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("stall_c2_final", 70'(mem_wb_bus[31:0]), 70'(32'h12345678));
    tick();
    @(negedge clk);
    chk("stall_c3_final", 70'(mem_wb_bus[31:0]), 70'(32'h12345678));
    tick();
    wb_allowin = 1'b1;
    @(negedge clk);
    chk("stall_rel_final", 70'(mem_wb_bus[31:0]), 70'(32'h12345678));
    chk("stall_rel_valid", 70'(mem_wb_valid), 70'(1'b1));
    tick();
    @(negedge clk);
    chk("stall_gone", 70'(mem_wb_valid), 70'(1'b0));

    // Back-to-back add then ld.w: the load must not see the add's buffered data
    exe_mem_valid = 1'b1;
    exe_mem_bus   = mk(1'b1, 1'b0, 5'd4, 32'h1C00_2000, 32'h0010_0000, 32'h5);
    tick();
    exe_mem_bus     = mk(1'b1, 1'b1, 5'd5, 32'h1C00_2004, {10'b0010100010, 22'h0}, 32'h200);
    data_sram_rdata = 32'h11111111;
    @(negedge clk);
    chk("b2b_add", mem_wb_bus, {1'b1, 5'd4, 32'h1C00_2000, 32'h5});
    chk("b2b_add_allowin", 70'(mem_allowin), 70'(1'b1));
    tick();
    exe_mem_valid   = 1'b0;
    data_sram_rdata = 32'h22222222;
    @(negedge clk);
    chk("b2b_ldw", mem_wb_bus, {1'b1, 5'd5, 32'h1C00_2004, 32'h22222222});
    chk("b2b_ldw_valid", 70'(mem_wb_valid), 70'(1'b1));
    tick();

    // Forwarding bus
    exe_mem_valid = 1'b1;
    exe_mem_bus   = mk(1'b1, 1'b0, 5'd7, 32'h1C00_3000, 32'h0010_0000, 32'hA);
    tick();
    exe_mem_valid = 1'b0;
    @(negedge clk);
    chk("byp_on", 70'(mem_wr_bus), 70'({1'b1, 5'd7, 32'hA}));
    tick();
    @(negedge clk);
    chk("byp_off", 70'(mem_wr_bus[37]), 70'(1'b0));

    // Reset in the middle of a stall
    exe_mem_valid = 1'b1;
    wb_allowin    = 1'b0;
    exe_mem_bus   = mk(1'b1, 1'b1, 5'd9, 32'h1C00_4000, {10'b0010100010, 22'h0}, 32'h300);
    tick();
    exe_mem_valid   = 1'b0;
    data_sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rs_pre_valid", 70'(mem_wb_valid), 70'(1'b1));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rs_valid", 70'(mem_wb_valid), 70'(1'b0));
    chk("rs_allowin", 70'(mem_allowin), 70'(1'b1));
    wb_allowin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rs_never_%0d", k), 70'(mem_wb_valid), 70'(1'b0));
    end
    tick();

    // Random traffic against the transaction-level model
    m_valid = 1'b0;
    m_first = 1'b0;
    m_bus   = '0;
    m_word  = '0;
    for (int c = 0; c < 500; c++) begin
      exe_mem_valid   = 1'($urandom_range(0, 1));
      wb_allowin      = ($urandom_range(0, 3) != 0);
      data_sram_rdata = $urandom;
      inst            = {ops[$urandom_range(0, 5)], 22'($urandom)};
      exe_mem_bus     = mk(1'($urandom), 1'($urandom), 5'($urandom), $urandom, inst, $urandom);
      @(negedge clk);
      chk("rnd_valid", 70'(mem_wb_valid), 70'(m_valid));
      chk("rnd_allowin", 70'(mem_allowin), 70'(!m_valid || wb_allowin));
      if (m_valid) begin
        word  = m_first ? data_sram_rdata : m_word;
        exp_f = ref_final(m_bus[63:32], m_bus[31:0], word, m_bus[101]);
        chk("rnd_wb_bus", mem_wb_bus, {m_bus[102], m_bus[100:96], m_bus[95:64], exp_f});
        chk("rnd_wr_bus", 70'(mem_wr_bus), 70'({m_bus[102], m_bus[100:96], exp_f}));
      end else begin
        chk("rnd_byp_idle", 70'(mem_wr_bus[37]), 70'(1'b0));
      end
      @(posedge clk);
      if (m_valid && m_first) m_word = data_sram_rdata;
      if (!m_valid || wb_allowin) begin
        if (exe_mem_valid) begin
          m_bus   = exe_mem_bus;
          m_first = 1'b1;
        end
        m_valid = exe_mem_valid;
      end else begin
        m_first = 1'b0;
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
